bus_dma_copy: RTL and testbench

//  Word-copy DMA engine. Acts as a bus initiator on the core's memory bus
//  (bus_en/wr_en/byte_en/addr/wr_data -> ack/rd_data) and is the peer of the
//  sp_ram responder. Copies i_len 32-bit words from i_src_addr to i_dst_addr,
//  one read then one write per word. It sits beside RISC_V behind a bus arbiter.

---
 rtl/dma_pkg.sv | 18 +
 rtl/bus_watchdog.sv | 29 ++
 rtl/bus_dma_copy.sv | 147 ++++++++++++++
 tb/tb_bus_dma_copy.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } dma_state_t;

    localparam logic [31:0] WORD_BYTES  = 32'd4;
    localparam logic [3:0]  BYTE_EN_ALL = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Request watchdog: cleared by i_load, counts cycles while i_run is high and
// flags o_expired in the TIMEOUT-th running cycle.
module bus_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign o_expired = i_run && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= '0;
        end else if (i_run && !o_expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bus_dma_copy.sv
// Word-copy DMA bus initiator: one read then one write per word, ascending.
// Optional request timeout/abort is enabled by defining DMA_TIMEOUT_EN.
module bus_dma_copy
    import dma_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    input  logic             i_ack,
    input  logic [31:0]      i_rd_data,
    output logic             o_bus_en,
    output logic             o_wr_en,
    output logic [31:0]      o_wr_data,
    output logic [31:0]      o_addr,
    output logic [3:0]       o_byte_en,
    output dma_state_t       o_dbg_state
);

    // Bus handshake: a request is offered while o_bus_en=1 and retires in the
    // single cycle i_ack=1; addr/wr_en/wr_data/byte_en never change before
    // that. Each request begins with an entry cycle where o_bus_en=0, so a
    // one-cycle-ack responder never sees the retired request a second time.
    dma_state_t       state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      data;
    logic             expired;

    assign o_dbg_state = state;

`ifdef DMA_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (!o_bus_en),
        .i_run     (o_bus_en),
        .o_expired (expired)
    );
`else
    assign expired = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            data      <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_bus_en  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_data <= '0;
            o_addr    <= '0;
            o_byte_en <= '0;
`ifdef DMA_TIMEOUT_EN
            o_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        src       <= word_align(i_src_addr);
                        dst       <= word_align(i_dst_addr);
                        remaining <= i_len;
                        o_busy    <= 1'b1;
`ifdef DMA_TIMEOUT_EN
                        o_err     <= 1'b0;
`endif
                        state     <= (i_len == '0) ? DONE : RD_REQ;
                    end
                end

                RD_REQ: begin
                    if (!o_bus_en) begin
                        o_bus_en  <= 1'b1;
                        o_wr_en   <= 1'b0;
                        o_addr    <= src;
                        o_byte_en <= BYTE_EN_ALL;
                    end else if (i_ack) begin
                        data      <= i_rd_data;
                        src       <= src + WORD_BYTES;
                        o_bus_en  <= 1'b0;
                        o_byte_en <= '0;
                        state     <= WR_REQ;
                    end else if (expired) begin
                        o_bus_en  <= 1'b0;
                        o_byte_en <= '0;
`ifdef DMA_TIMEOUT_EN
                        o_err     <= 1'b1;
`endif
                        state     <= DONE;
                    end
                end

                WR_REQ: begin
                    if (!o_bus_en) begin
                        o_bus_en  <= 1'b1;
                        o_wr_en   <= 1'b1;
                        o_addr    <= dst;
                        o_wr_data <= data;
                        o_byte_en <= BYTE_EN_ALL;
                    end else if (i_ack) begin
                        dst       <= dst + WORD_BYTES;
                        remaining <= remaining - 1'b1;
                        o_bus_en  <= 1'b0;
                        o_wr_en   <= 1'b0;
                        o_byte_en <= '0;
                        state     <= (remaining == LEN_W'(1)) ? DONE : RD_REQ;
                    end else if (expired) begin
                        o_bus_en  <= 1'b0;
                        o_wr_en   <= 1'b0;
                        o_byte_en <= '0;
`ifdef DMA_TIMEOUT_EN
                        o_err     <= 1'b1;
`endif
                        state     <= DONE;
                    end
                end

                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_copy.sv
// Bench for bus_dma_copy: sp_ram-style responder, sequential-copy reference
// model and directed plus randomized copies. Timeout steps need DMA_TIMEOUT_EN.
module tb_bus_dma_copy;
    import dma_pkg::*;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic             ack;
    logic [31:0]      rd_data;
    logic             bus_en;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [31:0]      addr;
    logic [3:0]       byte_en;
    dma_state_t       dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];

    int fixed_delay = 1;
    bit rand_delay  = 0;
    bit never_ack   = 0;
    int wcnt        = 0;
    int tgt         = 1;
    int done_cnt    = 0;
    int bus_cycles  = 0;

    logic        prev_bus;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [32:0] prev_wdata;

    bus_dma_copy #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_start     (start),
        .i_src_addr  (src_addr),
        .i_dst_addr  (dst_addr),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .i_ack       (ack),
        .i_rd_data   (rd_data),
        .o_bus_en    (bus_en),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .o_addr      (addr),
        .o_byte_en   (byte_en),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sp_ram responder: acks a request after a chosen number of cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            rd_data <= '0;
            wcnt     = 0;
        end else begin
            ack <= 1'b0;
            if (bus_en && !ack && !never_ack) begin
                if (wcnt == 0) tgt = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
                wcnt = wcnt + 1;
                if (wcnt >= tgt) begin
                    wcnt = 0;
                    ack <= 1'b1;
                    if (wr_en) begin
                        mem[addr[31:2]] = wr_data;
                        obs_q.push_back({1'b1, addr, wr_data});
                    end else begin
                        rd_data <= mem_rd(addr);
                        obs_q.push_back({1'b0, addr, mem_rd(addr)});
                    end
                end
            end
        end
    end

    // bus monitor: request stability and byte enables
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_en) bus_cycles++;
            if (done) done_cnt++;
            if (bus_en) check("byte_en", 65'(byte_en), 65'(4'hF));
            if (bus_en && prev_bus && !prev_ack) begin
                check("hold_addr", 65'(addr), 65'(prev_addr));
                check("hold_wdata", 65'({wr_en, wr_data}), 65'(prev_wdata));
            end
            prev_bus = bus_en;
        end else begin
            prev_bus = 1'b0;
        end
        prev_ack   = ack;
        prev_addr  = addr;
        prev_wdata = {wr_en, wr_data};
    end

    // driver tasks
    task automatic fill(input logic [31:0] base, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = base + 32'(4 * i);
            v = rnd ? $urandom : 32'h11 * 32'(i + 1);
            mem[a[31:2]]     = v;
            ref_mem[a[31:2]] = v;
        end
    endtask

    task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            logic [31:0] v;
            ra = s + 32'(4 * i);
            wa = d + 32'(4 * i);
            v  = ref_rd(ra);
            exp_q.push_back({1'b0, ra, v});
            exp_q.push_back({1'b1, wa, v});
            ref_mem[wa[31:2]] = v;
        end
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
        check("done_timeout", 65'(ok), 65'(1));
    endtask

    task automatic check_log();
        check("log_len", 65'(obs_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("log_entry", obs_q[i], exp_q[i]);
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        int d0;
        build_expect(s, d, n);
        d0 = done_cnt;
        start_copy(s, d, n);
        check("err_clear", 65'(err), 65'(0));
        check("busy_run", 65'(busy), 65'(1));
        wait_done(n * 2 * 8 + 20);
        @(negedge clk);
        check_log();
        check("done_count", 65'(done_cnt), 65'(d0 + 1));
        check("err_end", 65'(err), 65'(0));
        check("busy_end", 65'(busy), 65'(0));
        for (int i = 0; i < n; i++)
            check("dst_mem", 65'(mem_rd(d + 32'(4 * i))), 65'(ref_rd(d + 32'(4 * i))));
    endtask

    initial begin
        int b0;
        int d0;
        bit found;
        logic [31:0] s;
        logic [31:0] d;
        int n;

        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        rst_n    = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_bus_en", 65'(bus_en), 65'(0));
        check("rst_busy", 65'(busy), 65'(0));
        check("rst_done", 65'(done), 65'(0));
        check("rst_err", 65'(err), 65'(0));
        check("rst_addr", 65'({wr_en, byte_en, addr, wr_data}), 65'(0));
        check("rst_state", 65'(dbg_state), 65'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // basic 3-word copy, 1-cycle ack
        fixed_delay = 1;
        fill(32'h8000_0000, 3, 1'b0);
        run_copy(32'h8000_0000, 32'h8000_0100, 3);
        check("basic_w0", 65'(mem_rd(32'h8000_0100)), 65'(32'h11));
        check("basic_w1", 65'(mem_rd(32'h8000_0104)), 65'(32'h22));
        check("basic_w2", 65'(mem_rd(32'h8000_0108)), 65'(32'h33));

        // len = 0: done two cycles after start, no bus traffic
        b0 = bus_cycles;
        d0 = done_cnt;
        @(negedge clk);
        src_addr = 32'h8000_0000;
        len      = '0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("len0_done_c1", 65'({done, busy}), 65'(2'b01));
        @(negedge clk);
        check("len0_done_c2", 65'({done, busy}), 65'(2'b10));
        @(negedge clk);
        check("len0_done_c3", 65'(done), 65'(0));
        check("len0_no_bus", 65'(bus_cycles), 65'(b0));
        check("len0_one_done", 65'(done_cnt), 65'(d0 + 1));

        // wait states, start while busy is ignored
        fixed_delay = 5;
        fill(32'h2000_0000, 3, 1'b1);
        build_expect(32'h2000_0000, 32'h2000_0800, 3);
        b0 = bus_cycles;
        d0 = done_cnt;
        start_copy(32'h2000_0000, 32'h2000_0800, 3);
        repeat (9) @(negedge clk);
        start_copy(32'h3000_0000, 32'h3000_0100, 7);
        wait_done(200);
        @(negedge clk);
        check_log();
        check("ws_done_count", 65'(done_cnt), 65'(d0 + 1));
        check("ws_bus_cycles", 65'(bus_cycles - b0), 65'(6 * (5 + 1)));
        repeat (5) @(negedge clk);
        check("ws_still_idle", 65'(dbg_state), 65'(IDLE));

        // address wrap
        fixed_delay = 1;
        fill(32'hFFFF_FFFC, 2, 1'b1);
        run_copy(32'hFFFF_FFFC, 32'h0000_1000, 2);
        if (obs_q.size() >= 3) begin
            check("wrap_rd0", 65'(obs_q[0][63:32]), 65'(32'hFFFF_FFFC));
            check("wrap_rd1", 65'(obs_q[2][63:32]), 65'(32'h0000_0000));
        end else begin
            check("wrap_log_size", 65'(obs_q.size()), 65'(4));
        end

        // randomized copies, possibly overlapping, random ack latency
        rand_delay = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s = 32'h4000_0000 + 32'($urandom_range(0, 15) << 2);
            d = 32'h4000_0000 + 32'($urandom_range(0, 15) << 2);
            n = $urandom_range(1, 6);
            fill(s, n, 1'b1);
            run_copy(s, d, n);
        end
        rand_delay = 1'b0;

        // reset during a write request
        fixed_delay = 3;
        fill(32'h5000_0000, 4, 1'b1);
        start_copy(32'h5000_0000, 32'h5000_0100, 4);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus_en && wr_en) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_found_wr", 65'(found), 65'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus_en", 65'(bus_en), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_state", 65'(dbg_state), 65'(IDLE));
        check("rst_mid_busy", 65'(busy), 65'(0));
        b0 = bus_cycles;
        repeat (10) @(negedge clk);
        check("rst_no_resume", 65'(bus_cycles), 65'(b0));

`ifdef DMA_TIMEOUT_EN
        // responder never acks: abort after TIMEOUT cycles, next start clears err
        never_ack = 1'b1;
        b0 = bus_cycles;
        d0 = done_cnt;
        start_copy(32'h6000_0000, 32'h6000_0100, 2);
        wait_done(100);
        @(negedge clk);
        check("to_err", 65'(err), 65'(1));
        check("to_bus_cycles", 65'(bus_cycles - b0), 65'(TIMEOUT));
        check("to_done_count", 65'(done_cnt), 65'(d0 + 1));
        check("to_bus_off", 65'(bus_en), 65'(0));
        never_ack = 1'b0;
        fixed_delay = 1;
        fill(32'h6000_0000, 1, 1'b1);
        run_copy(32'h6000_0000, 32'h6000_0100, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

endmodule
